uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1_000_000, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, a power of two and at least 2.
REQ-004 SHALL have port clk  input  1  the single system clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  write strobe, one byte per cycle while high.
REQ-007 SHALL have port wr_data  input  8  byte to enqueue, sampled when wr_en=1.
REQ-008 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 SHALL have port empty  output  1  FIFO holds zero bytes.
REQ-010 SHALL have port busy  output  1  a frame is on the line, or the FIFO is non-empty.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-012 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-013 SHALL transmit 8N1 frames: start bit 0, 8 data bits LSB first, 1 stop bit of 1.
REQ-014 SHALL hold each bit for exactly DIV = CLK_FREQ/BAUD cycles (integer division, DIV >= 2); a frame is 10*DIV cycles.
REQ-015 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-016 SHALL transition STOP -> START directly, with no idle gap, when the FIFO is non-empty at the end of the stop bit.
REQ-017 SHALL pop the FIFO on the cycle it leaves IDLE or STOP for START, loading the byte into the shift register.
REQ-018 SHALL drive tx low on the cycle after a write that lands in an empty FIFO while in IDLE; write-to-start-bit latency is 1 cycle.
REQ-019 SHALL use a baud counter that counts 0..DIV-1 and wraps to 0, advancing the bit when it reaches DIV-1; a 3-bit bit index covers DATA bits 0..7.
REQ-020 SHALL drop a write made while full is 1, even if a pop occurs in the same cycle, and SHALL pulse overflow for that cycle only.
REQ-021 SHALL accept a write and a pop in the same cycle when the FIFO is not full, leaving the count unchanged.
REQ-022 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, and SHALL derive full/empty from a count of width $clog2(FIFO_DEPTH)+1.
REQ-023 SHALL assert busy = (state != IDLE) | ~empty.
REQ-024 SHALL drive all outputs from registers or from the FIFO count only, with no combinational path from wr_en to tx.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, tx=1, empty=1, full=0, busy=0, overflow=0, and clear the counters and pointers.
REQ-026 SHALL, on reset mid-frame, return tx high asynchronously and discard the partial frame and all queued bytes.
REQ-027 SHALL ignore wr_en during reset and on the first cycle after deassertion follow normal rules.

Structure
REQ-028 SHALL place the state enum (IDLE, START, DATA, STOP) and a DIV computation function in shared package uart_pkg.
REQ-029 SHALL instantiate the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst_n, push, pop, din, dout, full, empty).
REQ-030 SHALL implement the FSM, baud counter and shift register in uart_tx itself.

Verification (CLK_FREQ=10_000_000, BAUD=1_000_000, DIV=10, 10 MHz clock)
REQ-031 SHALL cover a single byte: write 0xA5 when idle -> tx low 1 cycle later for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop 1; busy low 100 cycles after the start bit begins.
REQ-032 SHALL cover back-to-back bytes: write 0x00,0xFF,0x55 on consecutive cycles -> three contiguous frames, 300 cycles, no idle gap, empty high after the third pop.
REQ-033 SHALL cover overflow: write 6 bytes on consecutive cycles, depth 4 -> the first pops immediately, 4 are queued, the 6th is dropped with a one-cycle overflow pulse, and 5 frames are transmitted.
REQ-034 SHALL cover a simultaneous write at full with a pop -> the write is dropped, overflow pulses, and the count decrements by 1.
REQ-035 SHALL cover reset mid-frame: assert rst_n=0 at cycle 45 of a frame -> tx=1 immediately, empty=1, and no further frames after release.
REQ-036 SHALL log the decoded bytes and compare them with the written bytes, with a PASS/FAIL count written to uart_tx.log.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come straight from the occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a transmit FIFO; frames run back-to-back while data is queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned BAUD       = 1_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  uart_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n;
  logic          bit_done;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;

  // A write into an empty FIFO while idle skips the queue (equivalent to
  // push+pop in one cycle) so the start bit appears on the next cycle.
  assign bypass    = (state == IDLE) & empty & wr_en;
  assign fifo_push = wr_en & ~bypass;
  assign bit_done  = (cnt == LAST);
  assign busy      = (state != IDLE) | ~empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    fifo_pop = 1'b0;
    if (state != IDLE) cnt_n = bit_done ? '0 : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n  = START;
          fifo_pop = 1'b1;
          sh_n     = fifo_dout;
        end else if (wr_en) begin
          state_n = START;
          sh_n    = wr_data;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            state_n  = START;
            fifo_pop = 1'b1;
            sh_n     = fifo_dout;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      tx       <= tx_n;
      overflow <= wr_en & full;
    end
  end

endmodule
